// File: rtl/compare_arbiter.sv
// compare_arbiter: round-robin arbiter that shares one comparison_unit
// among N_REQ requesters. One request is in flight at a time. The request
// is accepted in IDLE, compared in EXEC, and answered in RESP. The response
// channel carries the requester id and one-hot equal/less/greater flags.
//
// Handshakes (both channels): a transfer happens on a rising clock edge where
// valid && ready are both high. A requester keeps valid and its operands
// stable until ready. The response outputs stay stable while resp_valid is
// high and resp_ready is low.

// Signed comparator. Exactly one output is high for any operand pair.
module comparison_unit #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             equal,
  output logic             less,
  output logic             greater
);
  assign equal   = (a == b);
  assign less    = ($signed(a) < $signed(b));
  assign greater = !equal && !less;
endmodule

module compare_arbiter #(
  parameter int WIDTH = 32,
  parameter int N_REQ = 2,
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [IDW-1:0]         resp_id,
  output logic                   resp_equal,
  output logic                   resp_less,
  output logic                   resp_greater,
  output logic                   busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             resp_valid_q, resp_valid_d;
  logic             eq_q, eq_d;
  logic             lt_q, lt_d;
  logic             gt_q, gt_d;

  logic             found;
  logic [IDW-1:0]   gnt_idx;
  logic [IDW:0]     cand;
  logic [IDW:0]     ptr_inc;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic             cu_eq, cu_lt, cu_gt;

  comparison_unit #(.WIDTH(WIDTH)) u_cmp (
    .a       (a_q),
    .b       (b_q),
    .equal   (cu_eq),
    .less    (cu_lt),
    .greater (cu_gt)
  );

  // Circular search of req_valid starting at ptr; the first set bit wins.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = {1'b0, ptr_q} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(N_REQ)) cand = cand - (IDW+1)'(N_REQ);
      if (!found && req_valid[cand[IDW-1:0]]) begin
        found   = 1'b1;
        gnt_idx = cand[IDW-1:0];
      end
    end
  end

  // Operand mux for the winner, built with constant slices.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_idx == IDW'(i)) begin
        sel_a = req_a[i*WIDTH +: WIDTH];
        sel_b = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  // Grant: only the winner sees ready, only in IDLE, and never during reset.
  always_comb begin
    req_ready = '0;
    if (state_q == IDLE && found && !rst) req_ready[gnt_idx] = 1'b1;
  end

  // Next-state and datapath update for the IDLE -> EXEC -> RESP sequence.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    id_d         = id_q;
    a_d          = a_q;
    b_d          = b_q;
    resp_valid_d = resp_valid_q;
    eq_d         = eq_q;
    lt_d         = lt_q;
    gt_d         = gt_q;
    ptr_inc      = {1'b0, id_q} + (IDW+1)'(1);
    if (ptr_inc == (IDW+1)'(N_REQ)) ptr_inc = '0;
    case (state_q)
      IDLE: begin
        if (found) begin
          a_d     = sel_a;
          b_d     = sel_b;
          id_d    = gnt_idx;
          state_d = EXEC;
        end
      end
      EXEC: begin
        eq_d         = cu_eq;
        lt_d         = cu_lt;
        gt_d         = cu_gt;
        resp_valid_d = 1'b1;
        state_d      = RESP;
      end
      RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          ptr_d        = ptr_inc[IDW-1:0];
          state_d      = IDLE;
        end
      end
      default: begin
        resp_valid_d = 1'b0;
        state_d      = IDLE;
      end
    endcase
  end

  // State register; reset aborts any in-flight compare.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      id_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      resp_valid_q <= 1'b0;
      eq_q         <= 1'b0;
      lt_q         <= 1'b0;
      gt_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      id_q         <= id_d;
      a_q          <= a_d;
      b_q          <= b_d;
      resp_valid_q <= resp_valid_d;
      eq_q         <= eq_d;
      lt_q         <= lt_d;
      gt_q         <= gt_d;
    end
  end

  assign resp_valid   = resp_valid_q;
  assign resp_id      = id_q;
  assign resp_equal   = eq_q;
  assign resp_less    = lt_q;
  assign resp_greater = gt_q;
  assign busy         = (state_q != IDLE);

endmodule
